// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: PC control, I-cache request/response,
// redirect input and decode-side instruction handshake.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_address;
  logic            pc_write;
  logic [XLEN-1:0] pc_jmp_address;
  logic            pc_plus_4;
  logic            pc_plus_8;

  logic            cache_req;
  logic [XLEN-1:0] cache_address;
  logic            cache_valid;
  logic [63:0]     cache_data;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_address;

  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_address;
  logic            instr_ready;

  modport master (
    input  pc_address,
    output pc_write,
    output pc_jmp_address,
    output pc_plus_4,
    output pc_plus_8,
    output cache_req,
    output cache_address,
    input  cache_valid,
    input  cache_data,
    input  redirect_valid,
    input  redirect_address,
    output instr_valid,
    output instr,
    output instr_address,
    input  instr_ready
  );

  modport slave (
    output pc_address,
    input  pc_write,
    input  pc_jmp_address,
    input  pc_plus_4,
    input  pc_plus_8,
    input  cache_req,
    input  cache_address,
    output cache_valid,
    output cache_data,
    output redirect_valid,
    output redirect_address,
    input  instr_valid,
    input  instr,
    input  instr_address,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one aligned 64-bit request at a time,
// split into 32-bit words, queued and handed to decode.
module fetch_unit #(
  parameter int XLEN        = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] ISSUE_MAX = OW'(QUEUE_DEPTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW-1:0]   tail_p1;

  logic [31:0]     instr_q [QUEUE_DEPTH];
  logic [XLEN-1:0] iaddr_q [QUEUE_DEPTH];

  logic            redir;
  logic            issue;
  logic            accept;
  logic            hi;
  logic            q_valid;
  logic            pop;
  logic [1:0]      push_n;
  logic [31:0]     w0_data, w1_data;
  logic [XLEN-1:0] w0_addr, w1_addr;

  always_comb begin
    redir      = bus.redirect_valid & ~reset;
    state_d    = state_q;
    req_addr_d = req_addr_q;
    issue      = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redir && occ_q <= ISSUE_MAX) begin
          issue      = 1'b1;
          state_d    = WAIT;
          req_addr_d = bus.pc_address;
        end
      end
      WAIT: begin
        if (bus.cache_valid) begin
          accept  = !redir;
          state_d = IDLE;
        end else if (redir) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        // a coincident redirect still drains the stale beat
        if (bus.cache_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      issue  = 1'b0;
      accept = 1'b0;
    end
  end

  always_comb begin
    hi      = req_addr_q[2];
    push_n  = accept ? (hi ? 2'd1 : 2'd2) : 2'd0;
    w0_data = hi ? bus.cache_data[63:32]
                 : bus.cache_data[31:0];
    w0_addr = req_addr_q;
    w1_data = bus.cache_data[63:32];
    w1_addr = req_addr_q + XLEN'(4);
    tail_p1 = tail_q + PW'(1);
    q_valid = (occ_q != '0) && !redir && !reset;
    pop     = q_valid && bus.instr_ready;
    occ_d   = occ_q + OW'(push_n) - OW'(pop);
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push_n);
    if (redir) begin
      occ_d  = '0;
      head_d = '0;
      tail_d = '0;
    end
  end

  assign bus.pc_write       = redir;
  assign bus.pc_jmp_address = bus.redirect_address;
  assign bus.pc_plus_8      = accept & ~hi;
  assign bus.pc_plus_4      = accept & hi;
  assign bus.cache_req      = issue;
  assign bus.cache_address  = reset ? '0
    : {bus.pc_address[XLEN-1:3], 3'b000};
  assign bus.instr_valid    = q_valid;
  assign bus.instr          = reset ? '0 : instr_q[head_q];
  assign bus.instr_address  = reset ? '0 : iaddr_q[head_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      assert (32'(occ_q) + 32'(push_n) - 32'(pop)
              <= 32'(QUEUE_DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (push_n != 2'd0) begin
      instr_q[tail_q] <= w0_data;
      iaddr_q[tail_q] <= w0_addr;
    end
    if (push_n == 2'd2) begin
      instr_q[tail_p1] <= w1_data;
      iaddr_q[tail_p1] <= w1_addr;
    end
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that drives the program counter's control inputs (`write`, `jmp_address`, `plus_4`, `plus_8`) and consumes its `address` output. It issues one 8-byte-aligned request at a time to the instruction cache. It splits each 64-bit response into one or two 32-bit instructions, buffers them in a small queue, and hands them to decode over a valid/ready handshake. Branch and exception redirects enter here. They are forwarded to the PC, and the queue plus any in-flight request are squashed.

## Interface
- `XLEN`, 32, address/instruction width
- `QUEUE_DEPTH`, 4, instruction queue entries; power of two, ≥2
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `pc_address`  in  XLEN  current PC value
- `pc_write`  out  1  load PC with `pc_jmp_address`
- `pc_jmp_address`  out  XLEN  redirect target
- `pc_plus_4`  out  1  advance PC by 4
- `pc_plus_8`  out  1  advance PC by 8
- `cache_req`  out  1  one-cycle request pulse; cache always accepts
- `cache_address`  out  XLEN  `{pc_address[XLEN-1:3], 3'b000}`
- `cache_valid`  in  1  response strobe, ≥1 cycle after `cache_req`
- `cache_data`  in  64  `[31:0]` = word at +0, `[63:32]` = word at +4
- `redirect_valid`  in  1  redirect request from branch/commit logic
- `redirect_address`  in  XLEN  redirect target
- `instr_valid`  out  1  queue head valid
- `instr`  out  32  queue head instruction
- `instr_address`  out  XLEN  queue head address
- `instr_ready`  in  1  decode accepts head

## Operation
- FSM states are IDLE, WAIT and DISCARD. Reset value is IDLE.
- IDLE: `cache_req` = 1 when occupancy ≤ QUEUE_DEPTH−2 and `!redirect_valid`; the state then goes to WAIT and `req_addr` ← `pc_address`. Otherwise the FSM stays in IDLE.
- WAIT, on `cache_valid` with no redirect:
  - If `req_addr[2]==0`, push `cache_data[31:0]` @`req_addr`, then `cache_data[63:32]` @`req_addr+4`, and pulse `pc_plus_8`.
  - If `req_addr[2]==1`, push only `cache_data[63:32]` @`req_addr`, and pulse `pc_plus_4`.
  - The state then goes to IDLE.
- WAIT, on `redirect_valid` with no `cache_valid`: the state goes to DISCARD.
- WAIT, on `redirect_valid` and `cache_valid` in the same cycle: the response is dropped, no plus pulse is issued, and the state goes to IDLE.
- DISCARD: the next `cache_valid` is dropped and the state goes to IDLE. A further redirect while in DISCARD keeps the state in DISCARD.
- Redirect, in any state:
  - `pc_write` = `redirect_valid` and `pc_jmp_address` = `redirect_address`, both combinational.
  - `pc_plus_4` and `pc_plus_8` are forced to 0.
  - Queue occupancy ← 0 at the edge.
  - `instr_valid` is forced to 0 in that cycle, so no pop occurs.
- Queue: circular buffer with a `log2(QUEUE_DEPTH)+1`-bit occupancy counter.
  - Pop happens when `instr_valid && instr_ready`.
  - Push and pop in the same cycle are legal.
  - The issue gating above guarantees a push never overflows; an overflow is an assertion failure.
- At most one of `pc_write`, `pc_plus_8`, `pc_plus_4` is high in any cycle.
- Address arithmetic is modulo 2^XLEN; `req_addr+4` wraps.

## Timing
- During reset: FSM goes to IDLE, queue is emptied, and all outputs read 0. `pc_jmp_address` still follows `redirect_address`.
- The first `cache_req` is the first cycle after reset is deasserted. The PC's own reset has already forced address 0.
- A plus pulse is issued in the cycle `cache_valid` is accepted. `pc_address` shows the new value the next cycle, which is the earliest next IDLE issue.
- Steady-state throughput: one request per (cache latency + 1) cycles.
- A pushed instruction is visible on `instr_*` the cycle after the push.
- Redirect: the PC holds the target the cycle after `redirect_valid`. The first request to the target issues that same cycle if the state is IDLE. If the state was WAIT, the request issues only after the stale response is drained.
- Reset mid-WAIT: the outstanding response is the cache's responsibility to cancel. The fetch unit treats any `cache_valid` seen while in IDLE as stray and ignores it.

## Test plan
- Reset, PC=0, cache latency 1 → `cache_req` @0x0 in cycle 0, `pc_plus_8` in cycle 1, then instructions at 0x0 and 0x4 delivered in order, then a request @0x8 in cycle 2.
- Redirect to 0x104 → `pc_write` with target 0x104, request address 0x100, one instruction at 0x104 taken from `cache_data[63:32]`, and `pc_plus_4` pulsed.
- Hold `instr_ready`=0 with depth 4 → exactly 4 instructions queued, `cache_req` stays low, and a single pop does not restart issue until occupancy ≤2.
- Redirect in WAIT with latency 3 → state goes to DISCARD, the stale response is neither pushed nor pulses the PC, and the next request targets the redirect address.
- `redirect_valid` coincident with `cache_valid` → no push, no plus pulse, `pc_write`=1, queue emptied, and state goes to IDLE.
- Reset asserted mid-WAIT, followed by a late `cache_valid` → ignored, occupancy stays 0, and the next request is @0x0.
